pattern_count_engine: RTL and testbench

Hardware responder for the program-3 request/done handshake. On `req` it reads a 5-bit pattern and a 32-byte message from data memory and counts three things: pattern matches inside bytes, bytes with at least one match, and matches across the full 256-bit string. It then writes the three counts back to data memory and raises `done`. It sits beside data memory, in place of (or alongside) the software implementation on `top_level`, and uses the same memory map.

---
 rtl/pattern_count_engine.sv | 116 +++++++++++
 tb/tb_pattern_count_engine.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/pattern_count_engine.sv
// rtl/pattern_count_engine.sv - counts 5-bit pattern hits in a 32-byte message held in data memory
module pattern_count_engine #(
  parameter int PAT_ADDR  = 32,
  parameter int OUT_ADDR  = 33,
  parameter int MSG_BYTES = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  output logic       done,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_RDPAT, ST_SCAN, ST_WR0, ST_WR1, ST_WR2, ST_DONE
  } state_t;

  state_t     state;
  logic [4:0] pat;
  logic [7:0] ctb, cto, cts, prev, idx;
  logic [7:0] cross_bits;
  logic [2:0] m_in, m_cross;
  logic [7:0] ctb_nxt, cto_nxt, cts_nxt;

  // Cross windows span the previous byte's low nibble and the current byte's high nibble.
  always_comb begin
    cross_bits = {prev[3:0], mem_rd_data[7:4]};
    m_in = {2'b00, mem_rd_data[7:3] == pat} + {2'b00, mem_rd_data[6:2] == pat}
         + {2'b00, mem_rd_data[5:1] == pat} + {2'b00, mem_rd_data[4:0] == pat};
    m_cross = 3'd0;
    if (idx != 8'd0) begin
      m_cross = {2'b00, cross_bits[7:3] == pat} + {2'b00, cross_bits[6:2] == pat}
              + {2'b00, cross_bits[5:1] == pat} + {2'b00, cross_bits[4:0] == pat};
    end
    ctb_nxt = ctb + {5'b00000, m_in};
    cto_nxt = cto + {7'b0000000, m_in != 3'd0};
    cts_nxt = cts + {5'b00000, m_in} + {5'b00000, m_cross};
  end

  always_comb begin
    case (state)
      ST_RDPAT: mem_addr = 8'(PAT_ADDR);
      ST_SCAN:  mem_addr = idx;
      ST_WR0:   mem_addr = 8'(OUT_ADDR);
      ST_WR1:   mem_addr = 8'(OUT_ADDR + 1);
      ST_WR2:   mem_addr = 8'(OUT_ADDR + 2);
      default:  mem_addr = 8'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pat         <= 5'd0;
      ctb         <= 8'd0;
      cto         <= 8'd0;
      cts         <= 8'd0;
      prev        <= 8'd0;
      idx         <= 8'd0;
      done        <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'd0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (req) begin
            state <= ST_RDPAT;
            ctb   <= 8'd0;
            cto   <= 8'd0;
            cts   <= 8'd0;
            prev  <= 8'd0;
            idx   <= 8'd0;
            done  <= 1'b0;
          end
        end
        ST_RDPAT: begin
          pat   <= mem_rd_data[7:3];
          state <= ST_SCAN;
        end
        ST_SCAN: begin
          ctb  <= ctb_nxt;
          cto  <= cto_nxt;
          cts  <= cts_nxt;
          prev <= mem_rd_data;
          // The first write's data is loaded here so WR0 drives a registered value.
          if (idx == 8'(MSG_BYTES - 1)) begin
            state       <= ST_WR0;
            mem_wr_en   <= 1'b1;
            mem_wr_data <= ctb_nxt;
          end else begin
            idx <= idx + 8'd1;
          end
        end
        ST_WR0: begin
          state       <= ST_WR1;
          mem_wr_data <= cto;
        end
        ST_WR1: begin
          state       <= ST_WR2;
          mem_wr_data <= cts;
        end
        ST_WR2: begin
          state       <= ST_DONE;
          mem_wr_en   <= 1'b0;
          mem_wr_data <= 8'd0;
          done        <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_count_engine.sv
// tb/tb_pattern_count_engine.sv - randomized and directed checks against a bit-string reference model
module tb_pattern_count_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       req;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] msg [33];
  logic [7:0] res [3];
  int vectors = 0;
  int errors  = 0;

  pattern_count_engine dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = (mem_addr < 8'd33) ? msg[mem_addr[5:0]] : 8'h00;

  always @(posedge clk)
    if (mem_wr_en && mem_addr >= 8'd33 && mem_addr <= 8'd35)
      res[2'(mem_addr - 8'd33)] <= mem_wr_data;

  // Reference: treat the message as one 256-bit string and slide a 5-bit window over it.
  task automatic model(output int e_ctb, output int e_cto, output int e_cts);
    bit s [256];
    bit hit [32];
    logic [4:0] p;
    p = msg[32][7:3];
    e_ctb = 0; e_cto = 0; e_cts = 0;
    for (int i = 0; i < 256; i++) s[i] = msg[i / 8][7 - (i % 8)];
    for (int i = 0; i < 32; i++) hit[i] = 1'b0;
    for (int st = 0; st <= 251; st++) begin
      bit ok;
      ok = 1'b1;
      for (int k = 0; k < 5; k++) if (s[st + k] != p[4 - k]) ok = 1'b0;
      if (ok) begin
        e_cts++;
        if (st % 8 <= 3) begin
          e_ctb++;
          hit[st / 8] = 1'b1;
        end
      end
    end
    for (int i = 0; i < 32; i++) if (hit[i]) e_cto++;
  endtask

  task automatic fill(input logic [4:0] p, input logic [7:0] b);
    for (int i = 0; i < 32; i++) msg[i] = b;
    msg[32] = {p, 3'($urandom_range(0, 7))};
  endtask

  task automatic run(input int pulse_at, output int lat, output int wrc);
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    lat = 0; wrc = 0;
    while (!done && lat < 100) begin
      @(negedge clk); if (mem_wr_en) wrc++;
      @(posedge clk); #1 lat++;
      req = (lat == pulse_at);
    end
    req = 1'b0;
  endtask

  task automatic check_timing(input string name, input int lat, input int wrc);
    vectors += 2;
    if (lat !== 36) begin errors++; $display("FAIL %s latency got %0d want 36", name, lat); end
    if (wrc !== 3) begin errors++; $display("FAIL %s wr_cycles got %0d want 3", name, wrc); end
  endtask

  task automatic check_counts(input string name, input int a, input int b, input int c);
    vectors += 3;
    if (res[0] !== 8'(a)) begin errors++; $display("FAIL %s ctb got %0d want %0d", name, res[0], a); end
    if (res[1] !== 8'(b)) begin errors++; $display("FAIL %s cto got %0d want %0d", name, res[1], b); end
    if (res[2] !== 8'(c)) begin errors++; $display("FAIL %s cts got %0d want %0d", name, res[2], c); end
  endtask

  task automatic test_reset;
    reset = 1'b0; req = 1'b0;
    repeat (2) @(negedge clk);
    vectors += 4;
    if (done !== 1'b0)      begin errors++; $display("FAIL reset done got %b want 0", done); end
    if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL reset wr_en got %b want 0", mem_wr_en); end
    if (mem_addr !== 8'd0)  begin errors++; $display("FAIL reset addr got %0d want 0", mem_addr); end
    if (mem_wr_data !== 8'd0) begin errors++; $display("FAIL reset wr_data got %0d want 0", mem_wr_data); end
    reset = 1'b1;
  endtask

  task automatic test_directed;
    int lat, wrc;
    fill(5'b00000, 8'h00); run(-1, lat, wrc);
    check_timing("zeros", lat, wrc); check_counts("zeros", 128, 32, 252);
    for (int r = 0; r < 2; r++) begin
      fill(5'b10101, 8'h55); run(-1, lat, wrc);
      check_timing("alt", lat, wrc); check_counts("alt", 64, 32, 126);
    end
    fill(5'b11111, 8'h00); run(-1, lat, wrc); check_counts("absent", 0, 0, 0);
    fill(5'b11111, 8'hFF); run(-1, lat, wrc); check_counts("ones", 128, 32, 252);
    fill(5'b00011, 8'h00); msg[0] = 8'h01; msg[1] = 8'h80;
    run(-1, lat, wrc); check_counts("cross", 0, 0, 1);
  endtask

  task automatic test_reset_mid_scan;
    int lat, wrc, a, b, c;
    logic [7:0] saved [3];
    saved = res;
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    msg[32] = 8'($urandom);
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1 req = 1'b0;
    repeat (11) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    vectors += 5;
    if (done !== 1'b0)      begin errors++; $display("FAIL midrst done got %b want 0", done); end
    if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL midrst wr_en got %b want 0", mem_wr_en); end
    if (res[0] !== saved[0]) begin errors++; $display("FAIL midrst r33 got %0d want %0d", res[0], saved[0]); end
    if (res[1] !== saved[1]) begin errors++; $display("FAIL midrst r34 got %0d want %0d", res[1], saved[1]); end
    if (res[2] !== saved[2]) begin errors++; $display("FAIL midrst r35 got %0d want %0d", res[2], saved[2]); end
    @(negedge clk); reset = 1'b1;
    run(-1, lat, wrc); model(a, b, c);
    check_timing("after_rst", lat, wrc); check_counts("after_rst", a, b, c);
  endtask

  task automatic test_random_busy;
    int lat, wrc, a, b, c;
    for (int t = 0; t < 10; t++) begin
      for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
      // Sparse patterns sometimes, so low-entropy bytes produce many hits.
      if (t % 3 == 0) for (int i = 0; i < 32; i++) msg[i] = msg[i] & 8'($urandom);
      msg[32] = 8'($urandom);
      run($urandom_range(2, 33), lat, wrc); model(a, b, c);
      check_timing("rand", lat, wrc); check_counts("rand", a, b, c);
    end
  endtask

  task automatic test_back_to_back;
    int lat, a, b, c;
    for (int i = 0; i < 32; i++) msg[i] = 8'($urandom);
    msg[32] = 8'($urandom);
    model(a, b, c);
    @(negedge clk); req = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1 lat++; end
    vectors++;
    if (lat !== 36) begin errors++; $display("FAIL b2b first latency got %0d want 36", lat); end
    @(posedge clk); #1;
    vectors++;
    if (done !== 1'b0) begin errors++; $display("FAIL b2b restart done got %b want 0", done); end
    lat = 0;
    while (!done && lat < 100) begin @(posedge clk); #1 lat++; end
    req = 1'b0;
    vectors++;
    if (lat !== 36) begin errors++; $display("FAIL b2b second latency got %0d want 36", lat); end
    check_counts("b2b", a, b, c);
  endtask

  initial begin
    req = 1'b0; reset = 1'b1;
    for (int i = 0; i < 33; i++) msg[i] = 8'h00;
    test_reset;
    test_directed;
    test_reset_mid_scan;
    test_random_busy;
    test_back_to_back;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
